front_panel: RTL

FRONT_PANEL -- requirements
Module: front_panel

---
 rtl/front_panel.sv | 121 ++++++++++++
 1 files changed

// File: rtl/front_panel.sv
// front_panel: synchronised, debounced console buttons driving a HALT/RUN/STEP/STOPPING panel FSM with memory-write and PC-load ports
module front_panel #(
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 0,
  parameter int AUTO_INC = 0
) (
  input  logic             bclk,
  input  logic             rst,
  input  logic             dep,
  input  logic             incp,
  input  logic             ld,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] sw,
  input  logic             insn_done,
  output logic             run,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_value,
  output logic             halted
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
  typedef enum logic [1:0] {HALT, RUN, STEP, STOPPING} state_t;
  logic [4:0] btn, b1_q, b2_q, lvl_q, lvl_d, ev_q, ev_d;
  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s1_q, s2_q, addr_q, addr_d, wdata_q, wdata_d, pcv_q, pcv_d;
  logic [RW-1:0] rep_q, rep_d;
  logic mem_we_q, mem_we_d, pc_load_q, pc_load_d, rep_fire, e_incp;
  state_t state_q, state_d;
  assign btn = {stop, start, ld, incp, dep};
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lvl_d[i] = lvl_q[i];
      ev_d[i]  = 1'b0;
      cnt_d[i] = '0;
      if (b2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          lvl_d[i] = b2_q[i];
          ev_d[i]  = b2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign rep_fire = (REPEAT != 0) && lvl_q[1] && !ev_q[1] && rep_q == RW'(REPEAT - 1);
  assign rep_d    = (REPEAT == 0 || !lvl_q[1] || ev_q[1] || rep_fire) ? '0 : rep_q + 1'b1;
  assign e_incp   = ev_q[1] | rep_fire;
  always_comb begin
    state_d   = state_q;
    mem_we_d  = 1'b0;
    pc_load_d = 1'b0;
    addr_d    = (AUTO_INC != 0 && mem_we_q) ? addr_q + 1'b1 : addr_q;
    wdata_d   = wdata_q;
    pcv_d     = pcv_q;
    case (state_q)
      HALT:
        if (ev_q[2]) begin
          addr_d    = s2_q;
          pc_load_d = 1'b1;
          pcv_d     = s2_q;
        end else if (ev_q[0]) begin
          mem_we_d = 1'b1;
          wdata_d  = s2_q;
        end else if (e_incp) begin
          addr_d = addr_d + 1'b1;
        end else if (ev_q[3]) begin
          state_d = RUN;
        end else if (ev_q[4]) begin
          state_d = STEP;
        end
      RUN:      state_d = ev_q[4] ? (insn_done ? HALT : STOPPING) : RUN;
      STEP:     state_d = insn_done ? HALT : STEP;
      STOPPING: state_d = insn_done ? HALT : STOPPING;
    endcase
  end
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      b1_q      <= '0;
      b2_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      ev_q      <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      state_q   <= HALT;
      mem_we_q  <= 1'b0;
      pc_load_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pcv_q     <= '0;
    end else begin
      b1_q      <= btn;
      b2_q      <= b1_q;
      s1_q      <= sw;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      ev_q      <= ev_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      state_q   <= state_d;
      mem_we_q  <= mem_we_d;
      pc_load_q <= pc_load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pcv_q     <= pcv_d;
    end
  end
  assign run       = state_q != HALT;
  assign halted    = state_q == HALT;
  assign mem_we    = mem_we_q;
  assign pc_load   = pc_load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_value  = pcv_q;
endmodule
